mul_dispatch: RTL and testbench

- Upstream operand dispatcher for the 32x32 signed multipliers (`multi` fixed-latency, `multi_vl` variable-latency).
- Buffers operand pairs in a small FIFO and drives the multiplier start/operand handshake.
- Watches for the multiplier's valid pulse and enforces a timeout watchdog.
- Returns each product, with a measured latency and an error flag, on a valid/ready result stream.

---
 rtl/mul_dispatch.sv | 231 +++++++++++++++++++++++
 tb/tb_mul_dispatch.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_dispatch.sv
// rtl/mul_dispatch.sv - operand FIFO and start/valid dispatcher for the 32x32 signed multipliers
//
// Buffers operand pairs, issues them one at a time to a fixed- or
// variable-latency multiplier, guards each operation with a watchdog and
// returns product, measured latency and error flag on a result stream.
//
// Ports:
//   clock, reset                       rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready                 operand-pair handshake (in_ready = FIFO not full)
//   in_mlier, in_mcand                 signed operand pair
//   mul_start, mul_mlier, mul_mcand    registered request towards the multiplier
//   mul_prodt, mul_valid               multiplier product and result-valid pulse
//   out_valid, out_ready               result handshake
//   out_prodt, out_lat, out_err        product, start-high cycle count, timeout flag
//   busy                               queued, in-flight or unconsumed work present
module mul_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 34,
    parameter int GAP_CYC = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mlier,
    input  logic [31:0] in_mcand,
    output logic        mul_start,
    output logic [31:0] mul_mlier,
    output logic [31:0] mul_mcand,
    input  logic [63:0] mul_prodt,
    input  logic        mul_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_prodt,
    output logic [7:0]  out_lat,
    output logic        out_err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [7:0]  TIMEOUT_L = 8'(TIMEOUT);
    localparam logic [7:0]  GAP_L     = 8'(GAP_CYC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // ------------------------------------------------------------------
    // Operand FIFO: {mlier, mcand} per entry, pointers wrap naturally
    // because DEPTH is a power of two.
    // ------------------------------------------------------------------
    logic [63:0]   fifo_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [63:0]   head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_L);
    assign head       = fifo_mem_q[rd_ptr_q];
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;

    // ------------------------------------------------------------------
    // Dispatcher state
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic        start_q, start_d;
    logic [31:0] mlier_q, mlier_d;
    logic [31:0] mcand_q, mcand_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_prodt_q, out_prodt_d;
    logic [7:0]  out_lat_q, out_lat_d;
    logic        out_err_q, out_err_d;
    logic        result_accept;

    assign result_accept = out_valid_q && out_ready;

    // A new operation may start only when the result slot is free, or is
    // being emptied on this very edge, so a held result blocks issue.
    assign pop = (state_q == S_IDLE) && !fifo_empty && (!out_valid_q || out_ready);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        mlier_d     = mlier_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        gap_cnt_d   = gap_cnt_q;
        out_valid_d = out_valid_q;
        out_prodt_d = out_prodt_q;
        out_lat_d   = out_lat_q;
        out_err_d   = out_err_q;

        // Payload fields keep their values after the handshake; only the
        // valid flag drops.
        if (result_accept) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_ISSUE;
                    start_d = 1'b1;
                    mlier_d = head[63:32];
                    mcand_d = head[31:0];
                    cnt_d   = 8'd1;
                end
            end

            S_ISSUE: begin
                // Counter equals the number of start-high cycles so far.
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                // mul_valid is checked first so a product arriving on the
                // watchdog's final cycle is still accepted without error.
                if (mul_valid) begin
                    out_prodt_d = mul_prodt;
                    out_lat_d   = cnt_q;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    start_d     = 1'b0;
                    mlier_d     = '0;
                    mcand_d     = '0;
                    gap_cnt_d   = 8'd1;
                    state_d     = S_GAP;
                end else if (cnt_q == TIMEOUT_L) begin
                    out_prodt_d = '0;
                    out_lat_d   = TIMEOUT_L;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    start_d     = 1'b0;
                    mlier_d     = '0;
                    mcand_d     = '0;
                    gap_cnt_d   = 8'd1;
                    state_d     = S_GAP;
                end
            end

            S_GAP: begin
                // Late or spurious mul_valid pulses are ignored here.
                if (gap_cnt_q >= GAP_L) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                start_d = 1'b0;
                mlier_d = '0;
                mcand_d = '0;
            end
        endcase
    end

    // FIFO storage carries no reset; occupancy is defined by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {in_mlier, in_mcand};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            mlier_q     <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            gap_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_prodt_q <= '0;
            out_lat_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            start_q     <= start_d;
            mlier_q     <= mlier_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            out_valid_q <= out_valid_d;
            out_prodt_q <= out_prodt_d;
            out_lat_q   <= out_lat_d;
            out_err_q   <= out_err_d;
        end
    end

    assign mul_start = start_q;
    assign mul_mlier = mlier_q;
    assign mul_mcand = mcand_q;
    assign out_valid = out_valid_q;
    assign out_prodt = out_prodt_q;
    assign out_lat   = out_lat_q;
    assign out_err   = out_err_q;
    assign busy      = !fifo_empty || (state_q != S_IDLE) || out_valid_q;

endmodule

// File: tb/tb_mul_dispatch.sv
// tb/tb_mul_dispatch.sv - self-checking bench for mul_dispatch
module tb_mul_dispatch;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 34;
    localparam int GAP_CYC = 2;

    typedef struct packed {
        logic [63:0] prodt;
        logic [7:0]  lat;
        logic        err;
    } res_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mlier;
    logic [31:0] in_mcand;
    logic        mul_start;
    logic [31:0] mul_mlier;
    logic [31:0] mul_mcand;
    logic [63:0] mul_prodt = '0;
    logic        mul_valid = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prodt;
    logic [7:0]  out_lat;
    logic        out_err;
    logic        busy;

    always #5 clock = ~clock;

    mul_dispatch #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mlier (in_mlier),
        .in_mcand (in_mcand),
        .mul_start(mul_start),
        .mul_mlier(mul_mlier),
        .mul_mcand(mul_mcand),
        .mul_prodt(mul_prodt),
        .mul_valid(mul_valid),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_prodt(out_prodt),
        .out_lat  (out_lat),
        .out_err  (out_err),
        .busy     (busy)
    );

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    res_t got_q[$];
    int   got_rd = 0;

    // Multiplier model: per-operation latency taken in issue order,
    // 0 = never answers. Optional spurious pulse on the first low cycle.
    int   lat_arr[256];
    int   lat_wr  = 0;
    int   lat_rd  = 0;
    int   cur_lat = 0;
    int   hi_cnt  = 0;
    logic m_prev  = 1'b0;
    bit   spur_en = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            hi_cnt    = 0;
            lat_rd    = lat_wr;
            mul_valid = 1'b0;
            m_prev    = 1'b0;
        end else begin
            mul_valid = 1'b0;
            if (mul_start) begin
                if (!m_prev) begin
                    cur_lat = lat_arr[lat_rd % 256];
                    lat_rd++;
                    hi_cnt = 0;
                end
                hi_cnt++;
                if (cur_lat != 0 && hi_cnt == cur_lat) begin
                    mul_valid = 1'b1;
                    mul_prodt = longint'($signed(mul_mlier)) * longint'($signed(mul_mcand));
                end
            end else if (m_prev && spur_en) begin
                mul_valid = 1'b1;
                mul_prodt = {$urandom, $urandom};
            end
            m_prev = mul_start;
        end
    end

    // Observer: result capture, start-pulse run lengths, FIFO occupancy.
    int   occ          = 0;
    logic pending_push = 1'b0;
    logic s_prev       = 1'b0;
    int   low_len      = 0;
    int   hi_len       = 0;
    bit   seen_high    = 1'b0;
    int   rise_n       = 0;
    int   gap_arr[$];
    int   hi_arr[$];
    int   ready_err    = 0;
    int   full_seen    = 0;

    always @(negedge clock) begin
        if (reset) begin
            occ          = 0;
            pending_push = 1'b0;
            s_prev       = 1'b0;
            low_len      = 0;
            hi_len       = 0;
            seen_high    = 1'b0;
        end else begin
            if (mul_start && !s_prev) begin
                rise_n++;
                occ--;
                if (seen_high) gap_arr.push_back(low_len);
            end
            if (!mul_start && s_prev) hi_arr.push_back(hi_len);
            if (mul_start) begin
                hi_len    = s_prev ? hi_len + 1 : 1;
                seen_high = 1'b1;
                low_len   = 0;
            end else begin
                low_len++;
            end
            if (pending_push) occ++;
            if (in_ready !== (occ != DEPTH)) ready_err++;
            if (occ == DEPTH) full_seen++;
            pending_push = in_valid && in_ready;
            if (out_valid && out_ready) got_q.push_back('{out_prodt, out_lat, out_err});
            s_prev = mul_start;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input int lat);
        int   n;
        res_t e;
        n = 0;
        in_valid = 1'b1;
        in_mlier = a;
        in_mcand = b;
        while (!in_ready && n < 500) begin
            tick(1);
            n++;
            if (n > 3) out_ready = 1'b1;
        end
        check("push_accepted", in_ready, 1);
        tick(1);
        in_valid = 1'b0;
        lat_arr[lat_wr % 256] = lat;
        lat_wr++;
        if (lat >= 1 && lat <= TIMEOUT) begin
            e.prodt = longint'($signed(a)) * longint'($signed(b));
            e.lat   = 8'(lat);
            e.err   = 1'b0;
        end else begin
            e.prodt = '0;
            e.lat   = 8'(TIMEOUT);
            e.err   = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 3000) begin
            tick(1);
            k++;
        end
        check("results_arrived", got_q.size(), n);
    endtask

    task automatic drain();
        int   target;
        res_t r;
        res_t e;
        target = got_rd + exp_q.size();
        wait_results(target);
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            r = got_q[got_rd];
            check($sformatf("res_prodt#%0d", got_rd), r.prodt, e.prodt);
            check($sformatf("res_lat#%0d", got_rd), r.lat, e.lat);
            check($sformatf("res_err#%0d", got_rd), r.err, e.err);
            got_rd++;
        end
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int          base;
        int          g0;
        int          r0;
        int          unstable;
        int          k;
        int          sel;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic [72:0] held;
        logic [31:0] corner [4];

        corner[0] = 32'h8000_0000;
        corner[1] = 32'h7fff_ffff;
        corner[2] = 32'hffff_ffff;
        corner[3] = 32'h0000_0000;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mlier  = '0;
        in_mcand  = '0;
        out_ready = 1'b1;
        tick(3);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_mlier", mul_mlier, 0);
        check("rst_mul_mcand", mul_mcand, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_prodt", out_prodt, 0);
        check("rst_out_lat", out_lat, 0);
        check("rst_out_err", out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        tick(2);

        // 1: single fixed-latency-33 operation
        base = got_rd;
        push(32'h0000_0001, 32'h7fff_ffff, 33);
        drain();
        check("t1_prodt", got_q[base].prodt, 64'h0000_0000_7fff_ffff);
        check("t1_lat", got_q[base].lat, 33);
        check("t1_err", got_q[base].err, 0);
        check("t1_start_high_len", hi_arr[hi_arr.size()-1], 33);

        // 2: four corner-case pairs back to back
        base = got_rd;
        g0   = gap_arr.size();
        push(32'h7fff_ffff, 32'h7fff_ffff, 5);
        push(32'hffff_ffff, 32'h8000_0000, 5);
        push(32'h8000_0000, 32'h8000_0000, 5);
        push(32'h0000_0001, 32'h8000_0000, 5);
        drain();
        check("t2_p0", got_q[base].prodt,   64'h3fff_ffff_0000_0001);
        check("t2_p1", got_q[base+1].prodt, 64'h0000_0000_8000_0000);
        check("t2_p2", got_q[base+2].prodt, 64'h4000_0000_0000_0000);
        check("t2_p3", got_q[base+3].prodt, 64'hffff_ffff_8000_0000);
        check("t2_rises", gap_arr.size() - g0, 4);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t2_gap%0d", i), gap_arr[g0+i], GAP_CYC + 1);
        end

        // 3: watchdog abort, then a normal operation
        base = got_rd;
        push(32'h1234_5678, 32'h9abc_def0, 0);
        push(32'hffff_fffe, 32'h0000_0003, 7);
        drain();
        check("t3_err", got_q[base].err, 1);
        check("t3_prodt", got_q[base].prodt, 0);
        check("t3_lat", got_q[base].lat, TIMEOUT);
        check("t3_start_high_len", hi_arr[hi_arr.size()-2], TIMEOUT);
        check("t3_next_prodt", got_q[base+1].prodt, 64'hffff_ffff_ffff_fffa);
        check("t3_next_err", got_q[base+1].err, 0);

        // 4: back-pressure holds the result and blocks further issue
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push($urandom, $urandom, 4);
        check("t4_full_in_ready", in_ready, 0);
        check("t4_busy", busy, 1);
        k = 0;
        while (!out_valid && k < 100) begin
            tick(1);
            k++;
        end
        check("t4_valid_seen", out_valid, 1);
        held     = {out_prodt, out_lat, out_err};
        r0       = rise_n;
        unstable = 0;
        repeat (20) begin
            tick(1);
            if ({out_prodt, out_lat, out_err} !== held || out_valid !== 1'b1) unstable++;
        end
        check("t4_hold_stable", unstable, 0);
        check("t4_no_new_issue", rise_n, r0);
        check("t4_start_low", mul_start, 0);
        out_ready = 1'b1;
        tick(1);
        check("t4_issue_on_accept", mul_start, 1);
        check("t4_valid_cleared", out_valid, 0);
        drain();

        // 5: variable latency with spurious valid pulses in GAP
        base    = got_rd;
        g0      = gap_arr.size();
        spur_en = 1'b1;
        push(32'h0000_0003, 32'h0000_0005, 3);
        push(32'hffff_fff9, 32'h0000_0009, 17);
        drain();
        tick(30);
        spur_en = 1'b0;
        check("t5_lat0", got_q[base].lat, 3);
        check("t5_lat1", got_q[base+1].lat, 17);
        check("t5_no_extra", got_q.size(), got_rd);
        check("t5_gap", gap_arr[g0+1], GAP_CYC + 1);

        // randomized operands, latencies and back-pressure
        for (int i = 0; i < 24; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            sel = $urandom_range(0, 9);
            lat = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : (sel == 2) ? TIMEOUT + 3
                                                                    : $urandom_range(1, 12);
            push(a, b, lat);
        end
        out_ready = 1'b1;
        drain();

        // 6: reset during ISSUE with two pairs queued
        push(32'h0000_0011, 32'h0000_0022, 20);
        push(32'h0000_0033, 32'h0000_0044, 20);
        push(32'h0000_0055, 32'h0000_0066, 20);
        tick(5);
        check("t6_in_issue", mul_start, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_start", mul_start, 0);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        r0 = rise_n;
        g0 = got_q.size();
        tick(60);
        check("t6_no_issue", rise_n, r0);
        check("t6_no_result", got_q.size(), g0);
        check("t6_idle", busy, 0);

        check("ready_vs_occupancy", ready_err, 0);
        check("full_observed", full_seen > 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
